instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//  Byte-stream program loader: receives a framed program over a valid/ready byte
//  interface and writes 19-bit instructions into instruction memory. It is the
//  write side of the instruction memory that the pipeline fetch stage reads.
//  Holds the CPU (cpu_hold) until a complete frame loads with a good checksum.
// PARAMETERS
//  INST_WIDTH  19       instruction width; must be 17..24 (packed in 3 bytes)
//  ADDR_WIDTH  12       instruction memory address width
//  SYNC_BYTE   8'hA5    frame start marker
//  LOAD_BASE   12'h000  address of first instruction written
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           asynchronous reset, active-high
//  in_valid    in   1           byte available on in_data
//  in_data     in   8           stream byte
//  in_ready    out  1           loader accepts byte (transfer = in_valid & in_ready)
//  imem_we     out  1           instruction memory write strobe, 1 cycle
//  imem_addr   out  ADDR_WIDTH  write address
//  imem_wdata  out  INST_WIDTH  write data
//  cpu_hold    out  1           1 = keep CPU pipeline in reset/stall
//  done        out  1           last frame loaded successfully (level)
//  error       out  1           last frame aborted (level)
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, imem_we=0, imem_addr=LOAD_BASE, imem_wdata=0,
//   cpu_hold=1, done=0, error=0, count/checksum cleared. Reset mid-frame aborts
//   immediately; partial writes already issued are not undone.
//  Frame: SYNC, CNT_HI (bits[3:0]=N[11:8], bits[7:4] must be 0), CNT_LO (N[7:0]),
//   N x {B0,B1,B2} big-endian (inst = {B0,B1,B2}[INST_WIDTH-1:0]; unused top
//   bits of B0 must be 0), CHK = XOR of every byte after SYNC. N=0 legal.
//  States: IDLE -> CNT_HI -> CNT_LO -> (N>0 ? B0 : CHK); B0->B1->B2->WRITE;
//   WRITE -> (remaining>0 ? B0 : CHK); CHK -> DONE or ERR; DONE/ERR -> IDLE (1 cycle).
//  IDLE: in_ready=1; non-SYNC bytes discarded. Accepting SYNC: done<=0, error<=0,
//   cpu_hold<=1, imem_addr<=LOAD_BASE, checksum<=0.
//  Each state advances only on a transfer; in_valid low = wait indefinitely.
//  WRITE: in_ready=0 for exactly this cycle; imem_we=1, imem_wdata=assembled
//   word, imem_addr=current address. Latency: imem_we is the cycle after the B2
//   transfer. imem_addr increments after each write, wraps mod 2^ADDR_WIDTH.
//  Throughput: one instruction per 4 cycles max (3 bytes + write cycle).
//  Format violation (CNT_HI[7:4]!=0 or B0 spare bits!=0): next state ERR at once;
//   rest of frame is discarded in IDLE until next SYNC.
//  CHK: byte == running XOR -> DONE (done<=1, cpu_hold<=0); else ERR.
//  ERR: error<=1, cpu_hold stays 1. done/error hold until next SYNC accepted.
//  A SYNC value inside a frame is ordinary data (no resync).
//  imem_we never asserted outside WRITE; never asserted while rst=1.
// TESTING
//  1 Stream A5 00 02 01 23 45 07 FF FF 62 -> writes (0x000,0x12345),(0x001,0x7FFFF),
//    imem_we 1 cycle after each B2, done=1, error=0, cpu_hold 1->0 after CHK.
//  2 A5 00 00 00 -> no imem_we, done=1, cpu_hold=0; junk bytes 3C 11 before A5 ignored.
//  3 Case 1 with CHK=63 -> both writes occur, error=1, done=0, cpu_hold=1;
//    then case 1 again -> error clears on A5, done=1.
//  4 A5 00 01 08 00 00 -> error=1 after B0, no write; following 00 00 ignored.
//  5 LOAD_BASE=12'hFFF, A5 00 02 + two instrs + correct CHK -> writes at 0xFFF then 0x000.
//  6 rst pulsed after first write of case 1 -> all outputs at reset values; in_valid
//    gaps of 0..5 cycles between bytes give identical write sequence.

Source files
------------

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = stream source / memory side.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int INST_WIDTH = 19
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instruction_loader.sv
// Framed byte-stream program loader writing instructions into instruction memory.
// imem_we one cycle after each B2 byte; in_ready low during the write cycle and the DONE/ERR cycle.
module instruction_loader #(
  parameter int                    INST_WIDTH = 19,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [7:0]            SYNC_BYTE  = 8'hA5,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_loader_if.master  bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  // Bits of B0 above the instruction width; any of them set is a format violation.
  localparam logic [7:0] B0_SPARE = 8'(16'h00FF << (INST_WIDTH - 16));

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state;
  logic                    in_ready;
  logic                    imem_we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [INST_WIDTH-1:0]   wdata;
  logic [11:0]             remaining;
  logic [7:0]              chk;
  logic [INST_WIDTH-9:0]   hi_bytes;
  logic                    xfer;
  logic [7:0]              chk_nxt;

  assign xfer    = bus.in_valid & in_ready;
  assign chk_nxt = chk ^ bus.in_data;

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      addr      <= LOAD_BASE;
      wdata     <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      remaining <= '0;
      chk       <= '0;
      hi_bytes  <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (xfer && bus.in_data == SYNC_BYTE) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            addr     <= LOAD_BASE;
            chk      <= '0;
            state    <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (xfer) begin
            chk <= chk_nxt;
            if (bus.in_data[7:4] != 4'h0) begin
              error    <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_ERR;
            end else begin
              remaining[11:8] <= bus.in_data[3:0];
              state           <= S_CNT_LO;
            end
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            chk             <= chk_nxt;
            remaining[7:0]  <= bus.in_data;
            if ({remaining[11:8], bus.in_data} == 12'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_B0;
            end
          end
        end
        S_B0: begin
          if (xfer) begin
            chk <= chk_nxt;
            if ((bus.in_data & B0_SPARE) != 8'h00) begin
              error    <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_ERR;
            end else begin
              hi_bytes[INST_WIDTH-9:8] <= bus.in_data[INST_WIDTH-17:0];
              state                    <= S_B1;
            end
          end
        end
        S_B1: begin
          if (xfer) begin
            chk           <= chk_nxt;
            hi_bytes[7:0] <= bus.in_data;
            state         <= S_B2;
          end
        end
        S_B2: begin
          if (xfer) begin
            chk       <= chk_nxt;
            wdata     <= {hi_bytes, bus.in_data};
            imem_we   <= 1'b1;
            in_ready  <= 1'b0;
            remaining <= remaining - 12'd1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Address advances only once the write strobe has been presented.
          addr     <= addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          in_ready <= 1'b1;
          state    <= (remaining != 12'd0) ? S_B0 : S_CHK;
        end
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (bus.in_data == chk) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_DONE: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        S_ERR: begin
          error    <= 1'b1;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: two instances (LOAD_BASE 0x000 and 0xFFF) share one byte stream.
module tb_instruction_loader;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [18:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_hold_a, done_a, error_a;
  logic cpu_hold_b, done_b, error_b;

  instruction_loader_if #(.ADDR_WIDTH(12), .INST_WIDTH(19)) bus_a ();
  instruction_loader_if #(.ADDR_WIDTH(12), .INST_WIDTH(19)) bus_b ();

  assign bus_b.in_valid = bus_a.in_valid;
  assign bus_b.in_data  = bus_a.in_data;

  instruction_loader #(
    .INST_WIDTH(19), .ADDR_WIDTH(12), .SYNC_BYTE(8'hA5), .LOAD_BASE(12'h000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
  );

  instruction_loader #(
    .INST_WIDTH(19), .ADDR_WIDTH(12), .SYNC_BYTE(8'hA5), .LOAD_BASE(12'hFFF)
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int wr_a = 0;
  int wr_b = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  int  b2_t[$];
  logic [7:0]  frm[$];
  int          frm_b2[$];
  logic [18:0] frm_wd[$];

  // Write monitor: every strobe pops one expected write (cycle, address, data).
  always @(negedge clk) begin
    wr_t ea;
    wr_t eb;
    if (bus_a.imem_we === 1'b1) begin
      wr_a = wr_a + 1;
      total = total + 1;
      if (rst === 1'b1 || exp_a.size() == 0) begin
        bad = bad + 1;
        $display("FAIL wr_a_unexpected: got addr=%h data=%h cyc=%0d rst=%b, required no write", bus_a.imem_addr, bus_a.imem_wdata, cyc, rst);
      end else begin
        ea = exp_a.pop_front();
        if (bus_a.imem_addr !== ea.addr || bus_a.imem_wdata !== ea.data || cyc != ea.cyc) begin
          bad = bad + 1;
          $display("FAIL wr_a: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d", bus_a.imem_addr, bus_a.imem_wdata, cyc, ea.addr, ea.data, ea.cyc);
        end
      end
    end
    if (bus_b.imem_we === 1'b1) begin
      wr_b = wr_b + 1;
      total = total + 1;
      if (rst === 1'b1 || exp_b.size() == 0) begin
        bad = bad + 1;
        $display("FAIL wr_b_unexpected: got addr=%h data=%h cyc=%0d rst=%b, required no write", bus_b.imem_addr, bus_b.imem_wdata, cyc, rst);
      end else begin
        eb = exp_b.pop_front();
        if (bus_b.imem_addr !== eb.addr || bus_b.imem_wdata !== eb.data || cyc != eb.cyc) begin
          bad = bad + 1;
          $display("FAIL wr_b: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d", bus_b.imem_addr, bus_b.imem_wdata, cyc, eb.addr, eb.data, eb.cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one byte after `gap` idle cycles; t = cycle count seen just before the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    bit ok = 1'b0;
    t = -1;
    if (gap > 0) begin
      bus_a.in_valid = 1'b0;
      idle(gap);
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = b;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (bus_a.in_ready === 1'b1) begin
        t  = cyc;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus_a.in_valid = 1'b0;
    if (!ok) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL in_ready_timeout: byte %h not accepted in 40 cycles, required acceptance", b);
    end
  endtask

  // Sends a byte list; at each listed B2 position queues the write both loaders must make.
  task automatic send_stream(input logic [7:0] s[$], input int b2_at[$],
                             input logic [18:0] wd[$], input int maxgap);
    int  k = 0;
    int  t;
    int  gap;
    wr_t e;
    b2_t.delete();
    foreach (s[i]) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send_byte(s[i], gap, t);
      if (k < b2_at.size() && i == b2_at[k]) begin
        e.cyc  = t + 1;
        e.addr = 12'(k);
        e.data = wd[k];
        exp_a.push_back(e);
        e.addr = 12'hFFF + 12'(k);
        exp_b.push_back(e);
        b2_t.push_back(t);
        k++;
      end
    end
  endtask

  task automatic build_frame(input logic [23:0] ins[$], input bit corrupt);
    logic [7:0]  c = 8'h00;
    logic [11:0] n = 12'(ins.size());
    frm.delete();
    frm_b2.delete();
    frm_wd.delete();
    frm.push_back(8'hA5);
    frm.push_back({4'h0, n[11:8]});
    frm.push_back(n[7:0]);
    foreach (ins[i]) begin
      frm.push_back(ins[i][23:16]);
      frm.push_back(ins[i][15:8]);
      frm.push_back(ins[i][7:0]);
      frm_b2.push_back(3 + 3 * i + 2);
      frm_wd.push_back(ins[i][18:0]);
    end
    for (int i = 1; i < frm.size(); i++) c = c ^ frm[i];
    frm.push_back(corrupt ? ~c : c);
  endtask

  task automatic test_reset;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'h00;
    #1 rst = 1'b1;
    idle(3);
    total++;
    if ({bus_a.in_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, cpu_hold_a, done_a, error_a}
        !== {1'b1, 1'b0, 12'h000, 19'h0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_a: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, required 1 0 000 00000 1 0 0",
               bus_a.in_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, cpu_hold_a, done_a, error_a);
    end
    total++;
    if ({bus_b.in_ready, bus_b.imem_we, bus_b.imem_addr, cpu_hold_b, done_b, error_b}
        !== {1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_b: got rdy=%b we=%b addr=%h hold=%b done=%b err=%b, required 1 0 fff 1 0 0",
               bus_b.in_ready, bus_b.imem_we, bus_b.imem_addr, cpu_hold_b, done_b, error_b);
    end
    rst = 1'b0;
    idle(2);
    total++;
    if ({bus_a.in_ready, cpu_hold_a, done_a} !== 3'b110) begin
      bad++;
      $display("FAIL post_reset: got rdy=%b hold=%b done=%b, required 1 1 0", bus_a.in_ready, cpu_hold_a, done_a);
    end
  endtask

  task automatic test_basic;
    logic [7:0]  s[$];
    int          b2[$];
    logic [18:0] wd[$];
    int          t;
    s  = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF};
    b2 = '{5, 8};
    wd = '{19'h12345, 19'h7FFFF};
    send_stream(s, b2, wd, 0);
    idle(2);
    total++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b100) begin
      bad++;
      $display("FAIL basic_before_chk: got hold=%b done=%b err=%b, required 1 0 0", cpu_hold_a, done_a, error_a);
    end
    send_byte(8'h62, 0, t);
    idle(2);
    total++;
    if ({cpu_hold_a, done_a, error_a, cpu_hold_b, done_b} !== 5'b01001) begin
      bad++;
      $display("FAIL basic_done: got hold=%b done=%b err=%b hold_b=%b done_b=%b, required 0 1 0 0 1",
               cpu_hold_a, done_a, error_a, cpu_hold_b, done_b);
    end
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL basic_pending: got %0d/%0d writes missing, required 0/0", exp_a.size(), exp_b.size());
    end
  endtask

  task automatic test_empty;
    logic [7:0]  s[$];
    int          b2[$];
    logic [18:0] wd[$];
    int          wa = wr_a;
    s = '{8'h3C, 8'h11, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_stream(s, b2, wd, 0);
    idle(2);
    total++;
    if (wr_a != wa) begin
      bad++;
      $display("FAIL empty_writes: got %0d writes, required 0", wr_a - wa);
    end
    total++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b010) begin
      bad++;
      $display("FAIL empty_done: got hold=%b done=%b err=%b, required 0 1 0", cpu_hold_a, done_a, error_a);
    end
  endtask

  task automatic test_bad_chk;
    logic [7:0]  s[$];
    int          b2[$];
    logic [18:0] wd[$];
    int          t;
    s  = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h63};
    b2 = '{5, 8};
    wd = '{19'h12345, 19'h7FFFF};
    send_stream(s, b2, wd, 0);
    idle(2);
    total++;
    if ({cpu_hold_a, done_a, error_a, cpu_hold_b, error_b} !== 5'b10111) begin
      bad++;
      $display("FAIL badchk_err: got hold=%b done=%b err=%b hold_b=%b err_b=%b, required 1 0 1 1 1",
               cpu_hold_a, done_a, error_a, cpu_hold_b, error_b);
    end
    total++;
    if (exp_a.size() != 0) begin
      bad++;
      $display("FAIL badchk_writes: got %0d writes missing, required 0", exp_a.size());
    end
    send_byte(8'hA5, 0, t);
    total++;
    if ({error_a, done_a, cpu_hold_a} !== 3'b001) begin
      bad++;
      $display("FAIL badchk_sync_clear: got err=%b done=%b hold=%b, required 0 0 1", error_a, done_a, cpu_hold_a);
    end
    s  = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
    b2 = '{4, 7};
    send_stream(s, b2, wd, 0);
    idle(2);
    total++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b010) begin
      bad++;
      $display("FAIL badchk_reload: got hold=%b done=%b err=%b, required 0 1 0", cpu_hold_a, done_a, error_a);
    end
  endtask

  task automatic test_format;
    logic [7:0]  s[$];
    int          b2[$];
    logic [18:0] wd[$];
    int          t;
    int          wa = wr_a;
    s = '{8'hA5, 8'h00, 8'h01, 8'h08};
    send_stream(s, b2, wd, 0);
    idle(1);
    total++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b101) begin
      bad++;
      $display("FAIL fmt_b0: got hold=%b done=%b err=%b, required 1 0 1", cpu_hold_a, done_a, error_a);
    end
    s = '{8'h00, 8'h00};
    send_stream(s, b2, wd, 0);
    idle(2);
    total++;
    if (wr_a != wa || error_a !== 1'b1 || bus_a.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fmt_discard: got writes=%0d err=%b rdy=%b, required 0 1 1", wr_a - wa, error_a, bus_a.in_ready);
    end
    send_byte(8'hA5, 0, t);
    total++;
    if (error_a !== 1'b0) begin
      bad++;
      $display("FAIL fmt_sync_clear: got err=%b, required 0", error_a);
    end
    send_byte(8'h10, 0, t);
    idle(1);
    total++;
    if ({cpu_hold_a, error_a} !== 2'b11) begin
      bad++;
      $display("FAIL fmt_cnt_hi: got hold=%b err=%b, required 1 1", cpu_hold_a, error_a);
    end
  endtask

  task automatic test_wrap;
    logic [23:0] ins[$];
    ins = '{24'h054321, 24'h07ABCD};
    build_frame(ins, 1'b0);
    send_stream(frm, frm_b2, frm_wd, 0);
    idle(2);
    total++;
    if ({cpu_hold_b, done_b, error_b} !== 3'b010 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL wrap_done: got hold=%b done=%b err=%b pending=%0d, required 0 1 0 0",
               cpu_hold_b, done_b, error_b, exp_b.size());
    end
    total++;
    if (bus_b.imem_addr !== 12'h001 || bus_a.imem_addr !== 12'h002) begin
      bad++;
      $display("FAIL wrap_addr: got b=%h a=%h, required 001 002", bus_b.imem_addr, bus_a.imem_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] ins[$];
    ins = '{24'h000001, 24'h012345, 24'h06DEAD, 24'h03BEEF};
    build_frame(ins, 1'b0);
    send_stream(frm, frm_b2, frm_wd, 0);
    for (int i = 1; i < b2_t.size(); i++) begin
      total++;
      if (b2_t[i] - b2_t[i-1] != 4) begin
        bad++;
        $display("FAIL b2b_rate: got %0d cycles between instr %0d and %0d, required 4", b2_t[i] - b2_t[i-1], i - 1, i);
      end
    end
    ins = '{24'h070000, 24'h00FFFF};
    build_frame(ins, 1'b0);
    send_stream(frm, frm_b2, frm_wd, 0);
    idle(2);
    total++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b010 || exp_a.size() != 0) begin
      bad++;
      $display("FAIL b2b_done: got hold=%b done=%b err=%b pending=%0d, required 0 1 0 0",
               cpu_hold_a, done_a, error_a, exp_a.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0]  s[$];
    int          b2[$];
    logic [18:0] wd[$];
    s  = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45};
    b2 = '{5};
    wd = '{19'h12345};
    send_stream(s, b2, wd, 0);
    idle(2);
    rst = 1'b1;
    #2;
    total++;
    if ({bus_a.in_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, cpu_hold_a, done_a, error_a}
        !== {1'b1, 1'b0, 12'h000, 19'h0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_a: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, required 1 0 000 00000 1 0 0",
               bus_a.in_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, cpu_hold_a, done_a, error_a);
    end
    total++;
    if (bus_b.imem_addr !== 12'hFFF || exp_a.size() != 0) begin
      bad++;
      $display("FAIL midrst_b: got addr_b=%h pending=%0d, required fff 0", bus_b.imem_addr, exp_a.size());
    end
    idle(2);
    rst = 1'b0;
    idle(1);
    s  = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h62};
    b2 = '{5, 8};
    wd = '{19'h12345, 19'h7FFFF};
    send_stream(s, b2, wd, 5);
    idle(2);
    total++;
    if ({cpu_hold_a, done_a, error_a} !== 3'b010 || exp_a.size() != 0 || exp_b.size() != 0) begin
      bad++;
      $display("FAIL gaps_done: got hold=%b done=%b err=%b pending=%0d/%0d, required 0 1 0 0/0",
               cpu_hold_a, done_a, error_a, exp_a.size(), exp_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_bad_chk();
    test_format();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
